// File: rtl/pong_pkg.sv
// Shared screen/ball/paddle defaults, FSM state type and the signed coordinate
// helpers used by the Pong ball engine.
package pong_pkg;

  localparam int H_ACTIVE_DEF    = 640;
  localparam int V_ACTIVE_DEF    = 480;
  localparam int BALL_SIZE_DEF   = 5;
  localparam int PADDLE_W_DEF    = 10;
  localparam int PADDLE_H_DEF    = 120;
  localparam int TICK_DIV_DEF    = 125000;
  localparam int SPEED_MAX_DEF   = 4;
  localparam int HITS_PER_UP_DEF = 4;
  localparam int SERVE_TICKS_DEF = 60;
  localparam int WIN_SCORE_DEF   = 9;
  localparam int SCORE_W_DEF     = 4;

  // Two spare bits over the 10-bit screen coordinates keep edge tests free of wrap-around.
  localparam int COORD_W = 12;
  typedef logic signed [COORD_W-1:0] coord_t;

  typedef enum logic [1:0] {
    IDLE,
    SERVE,
    PLAY,
    GAME_OVER
  } state_e;

  function automatic coord_t to_coord(input logic [9:0] v);
    return coord_t'({2'b00, v});
  endfunction

  function automatic coord_t abs_c(input coord_t v);
    return v[COORD_W-1] ? -v : v;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running divider: tick_o is high for the single clk cycle in which the
// count wraps from TICK_DIV-1 back to 0.
module tick_gen
  import pong_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEF
) (
  input  logic clk,
  input  logic reset,
  output logic tick_o
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    tick_o = (cnt_q == CNT_LAST);
    cnt_d  = tick_o ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/ball_engine.sv
// Pong ball engine: ball motion, wall and paddle reflections, scoring and the
// serve/game FSM, all advanced by the motion tick from tick_gen.
module ball_engine
  import pong_pkg::*;
#(
  parameter int H_ACTIVE    = H_ACTIVE_DEF,
  parameter int V_ACTIVE    = V_ACTIVE_DEF,
  parameter int BALL_SIZE   = BALL_SIZE_DEF,
  parameter int PADDLE_W    = PADDLE_W_DEF,
  parameter int PADDLE_H    = PADDLE_H_DEF,
  parameter int TICK_DIV    = TICK_DIV_DEF,
  parameter int SPEED_MAX   = SPEED_MAX_DEF,
  parameter int HITS_PER_UP = HITS_PER_UP_DEF,
  parameter int SERVE_TICKS = SERVE_TICKS_DEF,
  parameter int WIN_SCORE   = WIN_SCORE_DEF,
  parameter int SCORE_W     = SCORE_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [9:0]         p1_x,
  input  logic [9:0]         p1_y,
  input  logic [9:0]         p2_x,
  input  logic [9:0]         p2_y,
  output logic [9:0]         ball_x,
  output logic [9:0]         ball_y,
  output logic               ball_live,
  output logic [SCORE_W-1:0] p1_score,
  output logic [SCORE_W-1:0] p2_score,
  output logic               point_p1,
  output logic               point_p2,
  output logic               game_over
);

  localparam int HALF  = BALL_SIZE / 2;
  localparam int SPD_W = $clog2(SPEED_MAX + 1);
  localparam int HIT_W = $clog2(HITS_PER_UP + 1);
  localparam int SRV_W = $clog2(SERVE_TICKS + 1);

  localparam coord_t HALF_C  = coord_t'(HALF);
  localparam coord_t PW_C    = coord_t'(PADDLE_W);
  localparam coord_t REACH_C = coord_t'(PADDLE_H / 2 + HALF);
  localparam coord_t ZERO_C  = coord_t'(0);
  localparam coord_t ONE_C   = coord_t'(1);
  localparam coord_t XMAX_C  = coord_t'(H_ACTIVE - 1);
  localparam coord_t YMAX_C  = coord_t'(V_ACTIVE - 1);

  localparam logic [9:0] X_MID  = 10'(H_ACTIVE / 2);
  localparam logic [9:0] Y_MID  = 10'(V_ACTIVE / 2);
  localparam logic [9:0] Y_TOP  = 10'(HALF);
  localparam logic [9:0] Y_BOT  = 10'(V_ACTIVE - 1 - HALF);
  localparam logic [9:0] P1_OFF = 10'(PADDLE_W + HALF);
  localparam logic [9:0] P2_OFF = 10'(1 + HALF);

  localparam logic [SPD_W-1:0]   SPD_ONE  = SPD_W'(1);
  localparam logic [SPD_W-1:0]   SPD_TOP  = SPD_W'(SPEED_MAX);
  localparam logic [HIT_W-1:0]   HIT_LAST = HIT_W'(HITS_PER_UP - 1);
  localparam logic [SRV_W-1:0]   SRV_LAST = SRV_W'(SERVE_TICKS - 1);
  localparam logic [SCORE_W-1:0] WIN_S    = SCORE_W'(WIN_SCORE);

  logic tick;

  state_e             state_q, state_d;
  logic [9:0]         x_q, x_d, y_q, y_d;
  logic               dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic [SPD_W-1:0]   speed_q, speed_d;
  logic [HIT_W-1:0]   hits_q, hits_d;
  logic [SRV_W-1:0]   serve_cnt_q, serve_cnt_d;
  logic [SCORE_W-1:0] p1_score_q, p1_score_d, p2_score_q, p2_score_d;
  logic [SCORE_W-1:0] p1_inc, p2_inc;
  logic               point_p1_q, point_p1_d, point_p2_q, point_p2_d;
  logic               recentre;

  coord_t xs, ys, spd, nx, ny, p1_face, p2_face;
  logic   wall_top, wall_bot, hit1, hit2, miss_l, miss_r;

  tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .tick_o(tick)
  );

  // Candidate step and every edge/paddle test are evaluated in signed 12-bit space.
  always_comb begin
    xs       = to_coord(x_q);
    ys       = to_coord(y_q);
    spd      = coord_t'(speed_q);
    nx       = dir_x_q ? xs + spd : xs - spd;
    ny       = dir_y_q ? ys + ONE_C : ys - ONE_C;
    wall_top = (ny - HALF_C) <= ZERO_C;
    wall_bot = (ny + HALF_C) >= YMAX_C;
    p1_face  = to_coord(p1_x) + PW_C;
    p2_face  = to_coord(p2_x) - ONE_C;
    hit1     = !dir_x_q && ((xs - HALF_C) >= p1_face) && ((nx - HALF_C) <= p1_face)
               && (abs_c(ys - to_coord(p1_y)) <= REACH_C);
    hit2     = dir_x_q && ((xs + HALF_C) <= p2_face) && ((nx + HALF_C) >= p2_face)
               && (abs_c(ys - to_coord(p2_y)) <= REACH_C);
    miss_l   = (nx - HALF_C) <= ZERO_C;
    miss_r   = (nx + HALF_C) >= XMAX_C;
  end

  assign p1_inc = (p1_score_q == WIN_S) ? WIN_S : p1_score_q + 1'b1;
  assign p2_inc = (p2_score_q == WIN_S) ? WIN_S : p2_score_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    dir_x_d     = dir_x_q;
    dir_y_d     = dir_y_q;
    speed_d     = speed_q;
    hits_d      = hits_q;
    serve_cnt_d = serve_cnt_q;
    p1_score_d  = p1_score_q;
    p2_score_d  = p2_score_q;
    point_p1_d  = 1'b0;
    point_p2_d  = 1'b0;
    recentre    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = SERVE;
          recentre = 1'b1;
        end
      end
      SERVE: begin
        if (tick) begin
          if (serve_cnt_q == SRV_LAST) begin
            state_d     = PLAY;
            serve_cnt_d = '0;
          end else begin
            serve_cnt_d = serve_cnt_q + 1'b1;
          end
        end
      end
      PLAY: begin
        // A paddle hit outranks a score; on a point the ball is not stepped.
        if (tick) begin
          if (hit1 || hit2) begin
            x_d     = hit1 ? p1_x + P1_OFF : p2_x - P2_OFF;
            dir_x_d = hit1;
            y_d     = wall_top ? Y_TOP : (wall_bot ? Y_BOT : ny[9:0]);
            dir_y_d = wall_top ? 1'b1 : (wall_bot ? 1'b0 : dir_y_q);
            if (hits_q == HIT_LAST) begin
              hits_d = '0;
              if (speed_q != SPD_TOP) speed_d = speed_q + 1'b1;
            end else begin
              hits_d = hits_q + 1'b1;
            end
          end else if (miss_l) begin
            point_p2_d = 1'b1;
            p2_score_d = p2_inc;
            dir_x_d    = 1'b0;
            if (p2_inc == WIN_S) state_d = GAME_OVER;
            else begin
              state_d  = SERVE;
              recentre = 1'b1;
            end
          end else if (miss_r) begin
            point_p1_d = 1'b1;
            p1_score_d = p1_inc;
            dir_x_d    = 1'b1;
            if (p1_inc == WIN_S) state_d = GAME_OVER;
            else begin
              state_d  = SERVE;
              recentre = 1'b1;
            end
          end else begin
            x_d     = nx[9:0];
            y_d     = wall_top ? Y_TOP : (wall_bot ? Y_BOT : ny[9:0]);
            dir_y_d = wall_top ? 1'b1 : (wall_bot ? 1'b0 : dir_y_q);
          end
        end
      end
      GAME_OVER: begin
        if (start) begin
          state_d    = SERVE;
          recentre   = 1'b1;
          p1_score_d = '0;
          p2_score_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (recentre) begin
      x_d         = X_MID;
      y_d         = Y_MID;
      speed_d     = SPD_ONE;
      hits_d      = '0;
      serve_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      x_q         <= X_MID;
      y_q         <= Y_MID;
      dir_x_q     <= 1'b1;
      dir_y_q     <= 1'b1;
      speed_q     <= SPD_ONE;
      hits_q      <= '0;
      serve_cnt_q <= '0;
      p1_score_q  <= '0;
      p2_score_q  <= '0;
      point_p1_q  <= 1'b0;
      point_p2_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      dir_x_q     <= dir_x_d;
      dir_y_q     <= dir_y_d;
      speed_q     <= speed_d;
      hits_q      <= hits_d;
      serve_cnt_q <= serve_cnt_d;
      p1_score_q  <= p1_score_d;
      p2_score_q  <= p2_score_d;
      point_p1_q  <= point_p1_d;
      point_p2_q  <= point_p2_d;
    end
  end

  assign ball_x    = x_q;
  assign ball_y    = y_q;
  assign ball_live = (state_q == PLAY);
  assign game_over = (state_q == GAME_OVER);
  assign p1_score  = p1_score_q;
  assign p2_score  = p2_score_q;
  assign point_p1  = point_p1_q;
  assign point_p2  = point_p2_q;

endmodule

// File: tb/tb_ball_engine.sv
// Scoreboard bench for ball_engine: a cycle-level game model pushes the expected
// outputs of every clk edge, each scenario task pops and compares them inline.
module tb_ball_engine;

  localparam int TICK_DIV    = 4;
  localparam int SERVE_TICKS = 2;
  localparam int WIN         = 3;
  localparam int H           = 640;
  localparam int V           = 480;
  localparam int HALF        = 2;
  localparam int PW          = 10;
  localparam int PH          = 120;
  localparam int SPEED_MAX   = 4;
  localparam int HITS_UP     = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [9:0] p1_x = 10'd20, p1_y = 10'd240, p2_x = 10'd610, p2_y = 10'd240;
  logic [9:0] ball_x, ball_y;
  logic       ball_live, point_p1, point_p2, game_over;
  logic [3:0] p1_score, p2_score;

  always #5 clk = ~clk;

  ball_engine #(
    .TICK_DIV   (TICK_DIV),
    .SERVE_TICKS(SERVE_TICKS),
    .WIN_SCORE  (WIN)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .p1_x     (p1_x),
    .p1_y     (p1_y),
    .p2_x     (p2_x),
    .p2_y     (p2_y),
    .ball_x   (ball_x),
    .ball_y   (ball_y),
    .ball_live(ball_live),
    .p1_score (p1_score),
    .p2_score (p2_score),
    .point_p1 (point_p1),
    .point_p2 (point_p2),
    .game_over(game_over)
  );

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       live;
    logic [3:0] s1;
    logic [3:0] s2;
    logic       pt1;
    logic       pt2;
    logic       go;
  } obs_t;

  obs_t expq[$];
  int   checks = 0;
  int   errors = 0;

  // Reference game state; mst: 0 idle, 1 serve, 2 play, 3 game over.
  int mst, mx, my, mdx, mdy, mspd, mhits, mserve, ms1, ms2, mpt1, mpt2, mdiv;
  int mhit_total = 0;
  bit p1_track = 1'b0;
  int p2_mode = 0;

  function automatic int absi(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic model_serve();
    mst = 1; mx = H / 2; my = V / 2; mspd = 1; mhits = 0; mserve = 0;
  endtask

  task automatic model_edge();
    int nx, ny, ty, tdy, p1x, p1y, p2x, p2y;
    bit tk, h1, h2;
    p1x = int'(p1_x); p1y = int'(p1_y); p2x = int'(p2_x); p2y = int'(p2_y);
    mpt1 = 0; mpt2 = 0;
    if (!reset) begin
      mst = 0; mx = H / 2; my = V / 2; ms1 = 0; ms2 = 0; mspd = 1; mhits = 0;
      mdx = 1; mdy = 1; mdiv = 0; mserve = 0;
      return;
    end
    tk = (mdiv == TICK_DIV - 1);
    mdiv = tk ? 0 : mdiv + 1;
    case (mst)
      0: if (start) model_serve();
      1: if (tk) begin
           mserve++;
           if (mserve == SERVE_TICKS) begin mst = 2; mserve = 0; end
         end
      2: if (tk) begin
           nx = mx + (mdx ? mspd : -mspd);
           ny = my + (mdy ? 1 : -1);
           ty = ny; tdy = mdy;
           if (ny - HALF <= 0) begin ty = HALF; tdy = 1; end
           else if (ny + HALF >= V - 1) begin ty = V - 1 - HALF; tdy = 0; end
           h1 = (mdx == 0) && (mx - HALF >= p1x + PW) && (nx - HALF <= p1x + PW)
                && (absi(my - p1y) <= PH / 2 + HALF);
           h2 = (mdx == 1) && (mx + HALF <= p2x - 1) && (nx + HALF >= p2x - 1)
                && (absi(my - p2y) <= PH / 2 + HALF);
           if (h1 || h2) begin
             mx = h1 ? p1x + PW + HALF : p2x - 1 - HALF;
             mdx = h1 ? 1 : 0; my = ty; mdy = tdy;
             mhit_total++; mhits++;
             if (mhits == HITS_UP) begin
               mhits = 0;
               if (mspd < SPEED_MAX) mspd++;
             end
           end else if (nx - HALF <= 0) begin
             if (ms2 < WIN) ms2++;
             mpt2 = 1; mdx = 0;
             if (ms2 == WIN) mst = 3; else model_serve();
           end else if (nx + HALF >= H - 1) begin
             if (ms1 < WIN) ms1++;
             mpt1 = 1; mdx = 1;
             if (ms1 == WIN) mst = 3; else model_serve();
           end else begin
             mx = nx; my = ty; mdy = tdy;
           end
         end
      3: if (start) begin ms1 = 0; ms2 = 0; model_serve(); end
      default: ;
    endcase
  endtask

  function automatic obs_t model_obs();
    obs_t o;
    o.x = 10'(mx); o.y = 10'(my); o.live = (mst == 2); o.s1 = 4'(ms1); o.s2 = 4'(ms2);
    o.pt1 = mpt1[0]; o.pt2 = mpt2[0]; o.go = (mst == 3);
    return o;
  endfunction

  function automatic obs_t dut_obs();
    obs_t o;
    o.x = ball_x; o.y = ball_y; o.live = ball_live; o.s1 = p1_score; o.s2 = p2_score;
    o.pt1 = point_p1; o.pt2 = point_p2; o.go = game_over;
    return o;
  endfunction

  // One clk edge: model follows the same edge, expectation queued, paddles steered.
  task automatic cycle();
    @(posedge clk);
    model_edge();
    expq.push_back(model_obs());
    @(negedge clk);
    if (p1_track) p1_y = 10'(my);
    case (p2_mode)
      1: p2_y = 10'(my);
      2: p2_y = (my < 240) ? 10'(my + 200) : 10'(my - 200);
      default: ;
    endcase
  endtask

  task automatic test_reset();
    obs_t e, a;
    reset = 1'b0; start = 1'b1;
    repeat (3) begin
      cycle();
      e = expq.pop_front(); a = dut_obs(); checks++;
      if (a !== e) begin errors++; $display("FAIL reset_sb actual %p required %p", a, e); end
    end
    checks++;
    if (ball_x !== 10'd320 || ball_y !== 10'd240 || ball_live !== 1'b0 || p1_score !== 4'd0
        || p2_score !== 4'd0 || point_p1 !== 1'b0 || point_p2 !== 1'b0 || game_over !== 1'b0) begin
      errors++;
      $display("FAIL reset_values actual x=%0d y=%0d live=%b s1=%0d s2=%0d required 320 240 0 0 0",
               ball_x, ball_y, ball_live, p1_score, p2_score);
    end
  endtask

  task automatic test_serve();
    obs_t e, a;
    bit moved = 1'b0;
    reset = 1'b1; p1_track = 1'b1; p2_mode = 1;
    for (int i = 0; i < 40 && !moved; i++) begin
      cycle();
      e = expq.pop_front(); a = dut_obs(); checks++;
      if (a !== e) begin errors++; $display("FAIL serve_sb cycle %0d actual %p required %p", i, a, e); end
      if (a.x != 10'd320) moved = 1'b1;
    end
    checks++;
    if (!moved || ball_x !== 10'd321 || ball_y !== 10'd241 || ball_live !== 1'b1) begin
      errors++;
      $display("FAIL first_step actual x=%0d y=%0d live=%b required 321 241 1", ball_x, ball_y, ball_live);
    end
  endtask

  task automatic test_rally();
    obs_t e, a;
    int min_x = 1000, min_y = 1000, max_y = 0, max_dx = 0, prev_x;
    bit done = 1'b0;
    prev_x = int'(ball_x);
    for (int i = 0; i < 40000 && !done; i++) begin
      cycle();
      e = expq.pop_front(); a = dut_obs(); checks++;
      if (a !== e) begin errors++; $display("FAIL rally_sb cycle %0d actual %p required %p", i, a, e); end
      if (a.live) begin
        if (int'(a.x) < min_x) min_x = int'(a.x);
        if (int'(a.y) < min_y) min_y = int'(a.y);
        if (int'(a.y) > max_y) max_y = int'(a.y);
        if (absi(int'(a.x) - prev_x) > max_dx) max_dx = absi(int'(a.x) - prev_x);
      end
      prev_x = int'(a.x);
      if (mhit_total >= 20) done = 1'b1;
    end
    checks++;
    if (!done) begin errors++; $display("FAIL rally_timeout actual hits=%0d required 20", mhit_total); end
    checks++;
    if (min_x != 32) begin errors++; $display("FAIL p1_hit_x actual %0d required 32", min_x); end
    checks++;
    if (min_y != 2) begin errors++; $display("FAIL top_wall_y actual %0d required 2", min_y); end
    checks++;
    if (max_y != 477) begin errors++; $display("FAIL bottom_wall_y actual %0d required 477", max_y); end
    checks++;
    if (max_dx != 4) begin errors++; $display("FAIL speed_cap actual %0d required 4", max_dx); end
  endtask

  task automatic test_miss();
    obs_t e, a;
    bit seen = 1'b0, moved = 1'b0;
    p2_mode = 2;
    for (int i = 0; i < 6000 && !seen; i++) begin
      cycle();
      e = expq.pop_front(); a = dut_obs(); checks++;
      if (a !== e) begin errors++; $display("FAIL miss_sb cycle %0d actual %p required %p", i, a, e); end
      if (a.pt1) seen = 1'b1;
    end
    checks++;
    if (!seen || p1_score !== 4'd1 || p2_score !== 4'd0 || ball_x !== 10'd320 || ball_y !== 10'd240
        || ball_live !== 1'b0) begin
      errors++;
      $display("FAIL miss_point actual seen=%b s1=%0d s2=%0d x=%0d y=%0d required 1 1 0 320 240",
               seen, p1_score, p2_score, ball_x, ball_y);
    end
    cycle();
    e = expq.pop_front(); a = dut_obs(); checks++;
    if (a !== e) begin errors++; $display("FAIL miss_sb_after actual %p required %p", a, e); end
    checks++;
    if (point_p1 !== 1'b0) begin errors++; $display("FAIL pulse_width actual %b required 0", point_p1); end
    for (int i = 0; i < 200 && !moved; i++) begin
      cycle();
      e = expq.pop_front(); a = dut_obs(); checks++;
      if (a !== e) begin errors++; $display("FAIL reserve_sb cycle %0d actual %p required %p", i, a, e); end
      if (a.x != 10'd320) moved = 1'b1;
    end
    checks++;
    if (ball_x !== 10'd321) begin errors++; $display("FAIL reserve_dir actual x=%0d required 321", ball_x); end
  endtask

  task automatic test_game_over();
    obs_t e, a;
    bit over = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 8000 && !over; i++) begin
      cycle();
      e = expq.pop_front(); a = dut_obs(); checks++;
      if (a !== e) begin errors++; $display("FAIL go_sb cycle %0d actual %p required %p", i, a, e); end
      if (a.go) over = 1'b1;
    end
    checks++;
    if (!over || p1_score !== 4'd3 || point_p1 !== 1'b1) begin
      errors++;
      $display("FAIL game_over_entry actual go=%b s1=%0d pt1=%b required 1 3 1", over, p1_score, point_p1);
    end
    repeat (20) begin
      cycle();
      e = expq.pop_front(); a = dut_obs(); checks++;
      if (a !== e) begin errors++; $display("FAIL frozen_sb actual %p required %p", a, e); end
    end
    checks++;
    if (game_over !== 1'b1 || ball_live !== 1'b0 || p1_score !== 4'd3) begin
      errors++;
      $display("FAIL game_over_hold actual go=%b live=%b s1=%0d required 1 0 3", game_over, ball_live, p1_score);
    end
    start = 1'b1;
    cycle();
    e = expq.pop_front(); a = dut_obs(); checks++;
    if (a !== e) begin errors++; $display("FAIL restart_sb actual %p required %p", a, e); end
    start = 1'b0;
    checks++;
    if (game_over !== 1'b0 || p1_score !== 4'd0 || p2_score !== 4'd0 || ball_x !== 10'd320
        || ball_y !== 10'd240 || ball_live !== 1'b0) begin
      errors++;
      $display("FAIL restart actual go=%b s1=%0d s2=%0d x=%0d y=%0d required 0 0 0 320 240",
               game_over, p1_score, p2_score, ball_x, ball_y);
    end
  endtask

  task automatic test_reset_mid_play();
    obs_t e, a;
    bit ready = 1'b0;
    for (int i = 0; i < 6000 && !ready; i++) begin
      cycle();
      e = expq.pop_front(); a = dut_obs(); checks++;
      if (a !== e) begin errors++; $display("FAIL midplay_sb cycle %0d actual %p required %p", i, a, e); end
      if (a.live && a.s1 == 4'd1 && a.x >= 10'd330) ready = 1'b1;
    end
    checks++;
    if (!ready) begin errors++; $display("FAIL midplay_timeout actual 0 required 1"); end
    reset = 1'b0;
    cycle();
    e = expq.pop_front(); a = dut_obs(); checks++;
    if (a !== e) begin errors++; $display("FAIL midreset_sb actual %p required %p", a, e); end
    checks++;
    if (ball_x !== 10'd320 || ball_y !== 10'd240 || ball_live !== 1'b0 || p1_score !== 4'd0
        || p2_score !== 4'd0 || point_p1 !== 1'b0 || point_p2 !== 1'b0 || game_over !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset actual x=%0d y=%0d live=%b s1=%0d s2=%0d required 320 240 0 0 0",
               ball_x, ball_y, ball_live, p1_score, p2_score);
    end
    reset = 1'b1;
    repeat (6) begin
      cycle();
      e = expq.pop_front(); a = dut_obs(); checks++;
      if (a !== e) begin errors++; $display("FAIL post_reset_sb actual %p required %p", a, e); end
    end
  endtask

  initial begin
    test_reset();
    test_serve();
    test_rally();
    test_miss();
    test_game_over();
    test_reset_mid_play();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
